// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor (Overflow only with SUB_OVERFLOW_EN)
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SUB_OVERFLOW_EN
  logic             Overflow;

  modport master (
    output In_Valid, A, B, Bin, Out_Ready,
    input  In_Ready, Out_Valid, Diff, Bout, Overflow
  );
  modport slave (
    input  In_Valid, A, B, Bin, Out_Ready,
    output In_Ready, Out_Valid, Diff, Bout, Overflow
  );
`else
  modport master (
    output In_Valid, A, B, Bin, Out_Ready,
    input  In_Ready, Out_Valid, Diff, Bout
  );
  modport slave (
    input  In_Valid, A, B, Bin, Out_Ready,
    output In_Ready, Out_Valid, Diff, Bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B-Bin through one full-subtractor cell; SUB_OVERFLOW_EN adds signed Overflow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;
`ifdef SUB_OVERFLOW_EN
  logic             r_ovf;
`endif

  logic w_a;
  logic w_b;
  logic w_d;
  logic w_borrow_nx;
  logic w_last;

  assign w_a         = r_a_sh[0];
  assign w_b         = r_b_sh[0];
  assign w_d         = w_a ^ w_b ^ r_borrow;
  assign w_borrow_nx = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
`ifdef SUB_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.In_Valid) begin
            r_a_sh   <= bus.A;
            r_b_sh   <= bus.B;
            r_borrow <= bus.Bin;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          // LSB-first: each difference bit enters at the MSB so bit 0 lands last
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_borrow <= w_borrow_nx;
          if (w_last) begin
            r_bout  <= w_borrow_nx;
`ifdef SUB_OVERFLOW_EN
            r_ovf   <= r_borrow ^ w_borrow_nx;
`endif
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.Out_Ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.In_Ready  = (r_state == S_IDLE);
  assign bus.Out_Valid = (r_state == S_DONE);
  assign bus.Diff      = r_diff;
  assign bus.Bout      = r_bout;
`ifdef SUB_OVERFLOW_EN
  assign bus.Overflow  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed vector table plus backpressure, reset and sweep sequences for serial_subtractor
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired got none expected event", name);
  endtask

  function automatic logic read_ovf();
`ifdef SUB_OVERFLOW_EN
    return bus.Overflow;
`else
    return 1'b0;
`endif
  endfunction

  // Full operation: optional idle gap, issue, measure latency, then complete output handshake.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int gap, input bit rnd_ready,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output int lat, output bit ok);
    bit acc;
    bit rdy_now;
    bit stable;
    ok = 1'b0;
    lat = 0;
    d = '0; bo = 1'b0; ov = 1'b0;
    stable = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.A = a; bus.B = b; bus.Bin = bin; bus.In_Valid = 1'b1;
    bus.Out_Ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      acc = bus.In_Ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    bus.In_Valid = 1'b0;
    if (!acc) begin
      fail_bound("accept_timeout");
      return;
    end
    for (int n = 1; n <= 40; n++) begin
      if (rnd_ready) bus.Out_Ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (bus.Out_Valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      fail_bound("out_valid_timeout");
      return;
    end
    d = bus.Diff; bo = bus.Bout; ov = read_ovf();
    for (int k = 0; k < 30; k++) begin
      if (k > 10) bus.Out_Ready = 1'b1;
      rdy_now = bus.Out_Ready;
      @(posedge clk); #1;
      if (rdy_now) break;
      if (!bus.Out_Valid || bus.Diff !== d || bus.Bout !== bo || read_ovf() !== ov) stable = 1'b0;
      if (rnd_ready) bus.Out_Ready = 1'($urandom_range(0, 1));
    end
    if (bus.Out_Valid) stable = 1'b0;
    bus.Out_Ready = 1'b1;
    ok = stable;
  endtask

  initial begin
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic [7:0] d_hold;
    int         lat;
    bit         ok;
    bit         seen;
    logic [8:0] exp9;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    int         sdiff;
    logic       exp_ov;

    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6]  = '{8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

    rst = 1'b1;
    bus.In_Valid = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0; bus.Out_Ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus.In_Ready), 32'd1);
    check("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
    check("rst_diff", 32'(bus.Diff), 32'h00);
    check("rst_bout", 32'(bus.Bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("rst_ovf", 32'(bus.Overflow), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.In_Ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, i % 3, 1'b0, d, bo, ov, lat, ok);
      check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
      check($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bout));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_handshake", i), 32'(ok), 32'd1);
`ifdef SUB_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
`endif
    end

    // Backpressure: hold result for 5 cycles while a second operand is offered.
    bus.A = 8'h5A; bus.B = 8'h3C; bus.Bin = 1'b0; bus.In_Valid = 1'b1; bus.Out_Ready = 1'b0;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.Out_Valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail_bound("bp_valid_timeout");
    d_hold = bus.Diff;
    check("bp_first_diff", 32'(d_hold), 32'h1E);
    bus.A = 8'h01; bus.B = 8'h02; bus.Bin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.In_Valid = 1'(k % 2);
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", k), 32'(bus.Out_Valid), 32'd1);
      check($sformatf("bp%0d_diff", k), 32'(bus.Diff), 32'h1E);
      check($sformatf("bp%0d_bout", k), 32'(bus.Bout), 32'd0);
      check($sformatf("bp%0d_in_ready", k), 32'(bus.In_Ready), 32'd0);
    end
    bus.In_Valid = 1'b1; bus.Out_Ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(bus.Out_Valid), 32'd0);
    check("bp_release_not_taken", 32'(bus.In_Ready), 32'd1);
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    check("bp_second_taken", 32'(bus.In_Ready), 32'd0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.Out_Valid) begin lat = n; break; end
    end
    if (lat == 0) fail_bound("bp_second_timeout");
    check("bp_second_latency", 32'(lat), 32'd8);
    check("bp_second_diff", 32'(bus.Diff), 32'hFF);
    check("bp_second_bout", 32'(bus.Bout), 32'd1);
    @(posedge clk); #1;

    // Reset during the third RUN cycle abandons the operation.
    bus.A = 8'h5A; bus.B = 8'h3C; bus.Bin = 1'b0; bus.In_Valid = 1'b1; bus.Out_Ready = 1'b1;
    @(posedge clk); #1;
    bus.In_Valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.Out_Valid), 32'd0);
    check("midrst_diff", 32'(bus.Diff), 32'h00);
    check("midrst_in_ready", 32'(bus.In_Ready), 32'd1);
    check("midrst_bout", 32'(bus.Bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h33, 8'h11, 1'b0, 0, 1'b0, d, bo, ov, lat, ok);
    check("after_rst_diff", 32'(d), 32'h22);
    check("after_rst_bout", 32'(bo), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom_range(0, 1));
      exp9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      sdiff = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      exp_ov = (sdiff > 127) || (sdiff < -128);
      do_op(ra, rb, rbin, $urandom_range(0, 3), 1'b1, d, bo, ov, lat, ok);
      check($sformatf("sweep%0d_result", i), 32'({bo, d}), 32'(exp9));
      check($sformatf("sweep%0d_hold", i), 32'(ok), 32'd1);
`ifdef SUB_OVERFLOW_EN
      check($sformatf("sweep%0d_ovf", i), 32'(ov), 32'(exp_ov));
`else
      if (exp_ov && ov) check("sweep_ovf_absent", 32'(ov), 32'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
